sonar_scheduler: RTL and testbench



---
 rtl/sonar_pkg.sv | 25 ++
 rtl/contador_bcd_3dig.sv | 46 ++++
 rtl/sonar_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_sonar_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and default timing constants for the sonar ranging path.
// Holds the FSM state encoding (also exported on db_estado) and BCD digit type.
package sonar_pkg;

    localparam int CM_CYCLES_DEF        = 2941;
    localparam int HALF_CM_DEF          = 1471;
    localparam int TRIG_CYCLES_DEF      = 500;
    localparam int ECHO_WAIT_CYCLES_DEF = 1_500_000;
    localparam int PERIOD_CYCLES_DEF    = 5_000_000;

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        PREPARA       = 4'h1,
        ENVIA_TRIGGER = 4'h2,
        ESPERA_ECHO   = 4'h3,
        MEDE          = 4'h4,
        ARREDONDA     = 4'h5,
        ARMAZENA      = 4'h6,
        FINAL         = 4'h7,
        ERRO          = 4'hF
    } state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/contador_bcd_3dig.sv
// Three-digit BCD up-counter with synchronous clear and increment enable.
// Ports: clock, reset (async, active-low), clear, inc -> value[11:0], overflow.
// overflow is combinational: high when inc is asserted while value is 999.
module contador_bcd_3dig
    import sonar_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [11:0] value,
    output logic        overflow
);

    bcd_digit_t d0;
    bcd_digit_t d1;
    bcd_digit_t d2;

    assign value    = {d2, d1, d0};
    assign overflow = inc && (d2 == 4'd9) && (d1 == 4'd9) && (d0 == 4'd9);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d0 <= '0;
            d1 <= '0;
            d2 <= '0;
        end else if (clear) begin
            d0 <= '0;
            d1 <= '0;
            d2 <= '0;
        end else if (inc) begin
            if (d0 == 4'd9) begin
                d0 <= '0;
                if (d1 == 4'd9) begin
                    d1 <= '0;
                    d2 <= (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
                end else begin
                    d1 <= d1 + 4'd1;
                end
            end else begin
                d0 <= d0 + 4'd1;
            end
        end
    end

endmodule

// File: rtl/sonar_scheduler.sv
// Ultrasonic ranging sequencer: trigger pulse, echo timing, rounded BCD centimetres.
// Ports: clock, reset (async, active-low), mensurar, continuo, echo ->
//   trigger, medida[11:0], pronto, erro, ocupado, db_estado[3:0].
// Optional periodic auto-measure is built when SONAR_PERIODIC_EN is defined.
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int CM_CYCLES        = CM_CYCLES_DEF,
    parameter int HALF_CM          = HALF_CM_DEF,
    parameter int TRIG_CYCLES      = TRIG_CYCLES_DEF,
    parameter int ECHO_WAIT_CYCLES = ECHO_WAIT_CYCLES_DEF,
    parameter int PERIOD_CYCLES    = PERIOD_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mensurar,
    input  logic        continuo,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        erro,
    output logic        ocupado,
    output logic [3:0]  db_estado
);

    localparam int TW = $clog2(CM_CYCLES);
    localparam int WMAX = (ECHO_WAIT_CYCLES > TRIG_CYCLES) ?
                          ECHO_WAIT_CYCLES : TRIG_CYCLES;
    localparam int WW = $clog2(WMAX);

    state_t          state;
    state_t          state_d;
    logic [TW-1:0]   tick;
    logic [WW-1:0]   cnt;
    logic            echo_s1;
    logic            echo_s2;
    logic            mens_q;
    logic            mens_q2;
    logic            mens_edge;
    logic            start;
    logic            bcd_clr;
    logic            bcd_inc;
    logic            bcd_ovf;
    logic [11:0]     bcd_value;

    assign mens_edge = mens_q && !mens_q2;

`ifdef SONAR_PERIODIC_EN
    localparam int PW = $clog2(PERIOD_CYCLES);

    logic [PW-1:0] per_cnt;
    logic          per_tick;

    // Held at zero while continuo is low so every enable restarts the period.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            per_cnt <= '0;
        end else if (!continuo) begin
            per_cnt <= '0;
        end else if (per_cnt == PW'(PERIOD_CYCLES - 1)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + 1'b1;
        end
    end

    assign per_tick = continuo && (per_cnt == PW'(PERIOD_CYCLES - 1));
    // Both sources only matter in INICIAL, so a coincident pair starts once
    // and a tick during a measurement is simply lost.
    assign start    = mens_edge || per_tick;
`else
    logic unused_continuo;
    assign unused_continuo = continuo;
    assign start           = mens_edge;
`endif

    contador_bcd_3dig u_bcd (
        .clock    (clock),
        .reset    (reset),
        .clear    (bcd_clr),
        .inc      (bcd_inc),
        .value    (bcd_value),
        .overflow (bcd_ovf)
    );

    always_comb begin
        state_d = state;
        bcd_clr = 1'b0;
        bcd_inc = 1'b0;
        unique case (state)
            INICIAL: begin
                if (start) state_d = PREPARA;
            end
            PREPARA: begin
                bcd_clr = 1'b1;
                state_d = ENVIA_TRIGGER;
            end
            ENVIA_TRIGGER: begin
                if (cnt == WW'(TRIG_CYCLES - 1)) state_d = ESPERA_ECHO;
            end
            ESPERA_ECHO: begin
                if (echo_s2) begin
                    state_d = MEDE;
                end else if (cnt == WW'(ECHO_WAIT_CYCLES - 1)) begin
                    state_d = ERRO;
                end
            end
            MEDE: begin
                if (!echo_s2) begin
                    state_d = ARREDONDA;
                end else if (tick == TW'(CM_CYCLES - 1)) begin
                    bcd_inc = 1'b1;
                    if (bcd_ovf) state_d = ERRO;
                end
            end
            ARREDONDA: begin
                state_d = ARMAZENA;
                if (tick >= TW'(HALF_CM)) begin
                    bcd_inc = 1'b1;
                    if (bcd_ovf) state_d = ERRO;
                end
            end
            ARMAZENA: state_d = FINAL;
            FINAL:    state_d = INICIAL;
            ERRO:     state_d = INICIAL;
            default:  state_d = INICIAL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= INICIAL;
            tick    <= '0;
            cnt     <= '0;
            echo_s1 <= 1'b0;
            echo_s2 <= 1'b0;
            mens_q  <= 1'b0;
            mens_q2 <= 1'b0;
            medida  <= '0;
            erro    <= 1'b0;
        end else begin
            state   <= state_d;
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            mens_q  <= mensurar;
            mens_q2 <= mens_q;

            if (state_d != state) begin
                cnt <= '0;
            end else if (state == ENVIA_TRIGGER || state == ESPERA_ECHO) begin
                cnt <= cnt + 1'b1;
            end

            // The cycle that leaves ESPERA_ECHO is already the first high
            // echo cycle, so the tick count starts at one.
            if (state == PREPARA) begin
                tick <= '0;
            end else if (state == ESPERA_ECHO && echo_s2) begin
                tick <= TW'(1);
            end else if (state == MEDE && echo_s2) begin
                tick <= (tick == TW'(CM_CYCLES - 1)) ? '0 : tick + 1'b1;
            end

            if (state == ARMAZENA) medida <= bcd_value;

            if (state_d == ERRO && state != ERRO) begin
                erro <= 1'b1;
            end else if (state_d == PREPARA) begin
                erro <= 1'b0;
            end
        end
    end

    assign trigger   = (state == ENVIA_TRIGGER);
    assign pronto    = (state == FINAL);
    assign ocupado   = (state != INICIAL);
    assign db_estado = state;

endmodule

// File: tb/tb_sonar_scheduler.sv
// Self-checking bench for sonar_scheduler with shortened timing parameters.
// Scoreboard holds expected medida/erro per measurement; a monitor pops on pronto or ERRO.
module tb_sonar_scheduler;

    localparam int CM     = 20;
    localparam int HALF   = 10;
    localparam int TRIG   = 5;
    localparam int WAIT   = 100;
    localparam int PERIOD = 400;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mensurar = 1'b0;
    logic        continuo = 1'b0;
    logic        echo = 1'b0;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        erro;
    logic        ocupado;
    logic [3:0]  db_estado;

    int          n_checks = 0;
    int          n_fail = 0;
    int          pronto_cnt = 0;
    int          cyc = 0;
    logic [11:0] exp_q[$];
    bit          exp_err_q[$];
    logic [11:0] model_medida = 12'h000;

    sonar_scheduler #(
        .CM_CYCLES        (CM),
        .HALF_CM          (HALF),
        .TRIG_CYCLES      (TRIG),
        .ECHO_WAIT_CYCLES (WAIT),
        .PERIOD_CYCLES    (PERIOD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .mensurar  (mensurar),
        .continuo  (continuo),
        .echo      (echo),
        .trigger   (trigger),
        .medida    (medida),
        .pronto    (pronto),
        .erro      (erro),
        .ocupado   (ocupado),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Expected result from echo width (cycles high); echo_on=0 means timeout.
    function automatic void push_exp(int w, bit echo_on);
        int cm;
        logic [11:0] bcd;
        if (!echo_on) begin
            exp_q.push_back(model_medida);
            exp_err_q.push_back(1'b1);
            return;
        end
        cm = w / CM;
        if ((w % CM) >= HALF) cm++;
        if (cm > 999) begin
            exp_q.push_back(model_medida);
            exp_err_q.push_back(1'b1);
        end else begin
            bcd = {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
            model_medida = bcd;
            exp_q.push_back(bcd);
            exp_err_q.push_back(1'b0);
        end
    endfunction

    always @(negedge clock) begin
        if (reset && (pronto || db_estado == 4'hF)) begin
            logic [11:0] e;
            bit ee;
            if (pronto) pronto_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: medida=%h erro=%b state=%h with empty scoreboard",
                         medida, erro, db_estado);
            end else begin
                e  = exp_q.pop_front();
                ee = exp_err_q.pop_front();
                if (medida !== e || erro !== ee || pronto === ee) begin
                    n_fail++;
                    $display("FAIL result: medida=%h erro=%b pronto=%b, expected medida=%h erro=%b",
                             medida, erro, pronto, e, ee);
                end
            end
        end
    end

    task automatic wait_idle(string name);
        int b = 0;
        while ((exp_q.size() != 0 || ocupado) && b < WAIT + 200) begin
            @(negedge clock);
            b++;
        end
        n_checks++;
        if (exp_q.size() != 0 || ocupado) begin
            n_fail++;
            $display("FAIL %s_timeout: pending=%0d ocupado=%b, expected 0 and 0",
                     name, exp_q.size(), ocupado);
        end
    endtask

    task automatic run_meas(int w, bit echo_on, bit poke);
        int b;
        push_exp(w, echo_on);
        @(negedge clock);
        mensurar = 1'b1;
        repeat (2) @(negedge clock);
        mensurar = 1'b0;
        b = 0;
        while (!trigger && b < 10) begin
            @(negedge clock);
            b++;
        end
        while (trigger && b < TRIG + 20) begin
            @(negedge clock);
            b++;
        end
        n_checks++;
        if (trigger || b >= TRIG + 20) begin
            n_fail++;
            $display("FAIL trigger_window: trigger=%b waited=%0d", trigger, b);
        end
        repeat (3) @(negedge clock);
        if (echo_on) begin
            echo = 1'b1;
            for (int i = 0; i < w; i++) begin
                if (poke) mensurar = ((i % 4) < 2);
                @(negedge clock);
            end
            echo = 1'b0;
            mensurar = 1'b0;
        end
        wait_idle("meas");
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({trigger, pronto, erro, ocupado, db_estado} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: trig/pronto/erro/ocup/estado=%b, expected 0",
                     {trigger, pronto, erro, ocupado, db_estado});
        end
        n_checks++;
        if (medida !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_medida: medida=%h, expected 000", medida);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_latency;
        int tw = 0;
        int p0;
        push_exp(3 * CM + 4, 1'b1);
        @(negedge clock);
        mensurar = 1'b1;
        @(posedge clock);
        @(posedge clock);
        #1;
        n_checks++;
        if (db_estado !== 4'h1 || !ocupado) begin
            n_fail++;
            $display("FAIL start_prepara: estado=%h ocupado=%b, expected 1 and 1", db_estado, ocupado);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (db_estado !== 4'h2 || trigger !== 1'b1) begin
            n_fail++;
            $display("FAIL start_trigger: estado=%h trigger=%b, expected 2 and 1", db_estado, trigger);
        end
        mensurar = 1'b0;
        while (trigger && tw < TRIG + 10) begin
            tw++;
            @(posedge clock);
            #1;
        end
        n_checks++;
        if (tw != TRIG) begin
            n_fail++;
            $display("FAIL trigger_width: width=%0d, expected %0d", tw, TRIG);
        end
        repeat (3) @(negedge clock);
        echo = 1'b1;
        repeat (3 * CM + 4) @(negedge clock);
        echo = 1'b0;
        p0 = pronto_cnt;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (db_estado !== 4'h5) begin
            n_fail++;
            $display("FAIL end_arredonda: estado=%h, expected 5", db_estado);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (db_estado !== 4'h6 || pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL end_armazena: estado=%h pronto=%b, expected 6 and 0", db_estado, pronto);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (db_estado !== 4'h7 || pronto !== 1'b1 || medida !== 12'h003) begin
            n_fail++;
            $display("FAIL end_final: estado=%h pronto=%b medida=%h, expected 7 1 003",
                     db_estado, pronto, medida);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (pronto !== 1'b0 || ocupado !== 1'b0) begin
            n_fail++;
            $display("FAIL end_pulse: pronto=%b ocupado=%b, expected 0 and 0", pronto, ocupado);
        end
        wait_idle("latency");
        n_checks++;
        if (pronto_cnt - p0 != 1) begin
            n_fail++;
            $display("FAIL latency_pronto_count: count=%0d, expected 1", pronto_cnt - p0);
        end
    endtask

    task automatic test_rounding;
        int widths[8] = '{100 * CM, 100 * CM + HALF - 1, 74 * CM + 13, 74 * CM + 9,
                          1, HALF, 999 * CM + HALF - 1, 999 * CM + HALF};
        foreach (widths[i]) run_meas(widths[i], 1'b1, 1'b0);
    endtask

    task automatic test_no_echo;
        run_meas(0, 1'b0, 1'b0);
        n_checks++;
        if (erro !== 1'b1 || db_estado !== 4'h0) begin
            n_fail++;
            $display("FAIL erro_held: erro=%b estado=%h, expected 1 and 0", erro, db_estado);
        end
        run_meas(2 * CM + 5, 1'b1, 1'b0);
        n_checks++;
        if (erro !== 1'b0 || medida !== 12'h002) begin
            n_fail++;
            $display("FAIL erro_cleared: erro=%b medida=%h, expected 0 and 002", erro, medida);
        end
    endtask

    task automatic test_mid_reset;
        push_exp(50, 1'b1);
        @(negedge clock);
        mensurar = 1'b1;
        repeat (2) @(negedge clock);
        mensurar = 1'b0;
        repeat (TRIG + 3) @(negedge clock);
        echo = 1'b1;
        repeat (10) @(negedge clock);
        n_checks++;
        if (db_estado !== 4'h4) begin
            n_fail++;
            $display("FAIL reach_mede: estado=%h, expected 4", db_estado);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({trigger, pronto, erro, ocupado, db_estado} !== 8'h00 || medida !== 12'h000) begin
            n_fail++;
            $display("FAIL async_reset: ctrl=%b medida=%h, expected 0 and 000",
                     {trigger, pronto, erro, ocupado, db_estado}, medida);
        end
        exp_q.delete();
        exp_err_q.delete();
        model_medida = 12'h000;
        echo = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_busy;
        int p0 = pronto_cnt;
        run_meas(CM + HALF, 1'b1, 1'b1);
        repeat (20) @(negedge clock);
        n_checks++;
        if (pronto_cnt - p0 != 1 || db_estado !== 4'h0) begin
            n_fail++;
            $display("FAIL busy_ignore: prontos=%0d estado=%h, expected 1 and 0",
                     pronto_cnt - p0, db_estado);
        end
    endtask

`ifdef SONAR_PERIODIC_EN
    task automatic test_periodic;
        int b;
        int t_prev = 0;
        int p0;
        continuo = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b = 0;
            while (!trigger && b < PERIOD + 50) begin
                @(negedge clock);
                b++;
            end
            n_checks++;
            if (!trigger) begin
                n_fail++;
                $display("FAIL periodic_start: no trigger in %0d cycles", b);
            end else if (k > 0 && cyc - t_prev != PERIOD) begin
                n_fail++;
                $display("FAIL periodic_interval: interval=%0d, expected %0d", cyc - t_prev, PERIOD);
            end
            t_prev = cyc;
            push_exp(CM, 1'b1);
            repeat (TRIG + 3) @(negedge clock);
            echo = 1'b1;
            repeat (CM) @(negedge clock);
            echo = 1'b0;
            wait_idle("periodic");
        end
        continuo = 1'b0;
        p0 = pronto_cnt;
        repeat (2 * PERIOD) @(negedge clock);
        n_checks++;
        if (pronto_cnt != p0 || ocupado) begin
            n_fail++;
            $display("FAIL periodic_stop: prontos=%0d ocupado=%b, expected 0 and 0",
                     pronto_cnt - p0, ocupado);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_latency;
        test_rounding;
        test_no_echo;
        test_mid_reset;
        test_busy;
`ifdef SONAR_PERIODIC_EN
        test_periodic;
`endif
        repeat (5) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
